idu_hazard_ctrl: RTL

// - Issue scheduler between the decode pipe (idu0/idu1) and the execution units.
// - Holds a 32-entry register scoreboard for long-latency writers (MUL, DIV, LOAD).
// - Checks the decoded instruction for RAW, WAW and divider structural hazards.
// - Drives the pipe_stall / pipe_flush pair consumed by every decode-stage output flop.

---
 rtl/idu_hazard_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/idu_hazard_ctrl.sv
// Issue scheduler between decode and execute: tracks long-latency destinations in a
// register scoreboard, detects RAW/WAW/divider hazards and drives pipe_stall/pipe_flush.
module idu_hazard_ctrl #(
  parameter  int NUM_REGS = 32,
  parameter  int CNT_W    = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  input  logic                dec_rs1,
  input  logic [AW-1:0]       dec_rs1_addr,
  input  logic                dec_rs2,
  input  logic [AW-1:0]       dec_rs2_addr,
  input  logic                dec_rd,
  input  logic [AW-1:0]       dec_rd_addr,
  input  logic                dec_long,
  input  logic                dec_div,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd_addr,
  input  logic                div_done,
  input  logic                ext_stall,
  input  logic                flush_req,
  output logic                pipe_stall,
  output logic                pipe_flush,
  output logic                issue,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  div_state_e          r_div_state;
  logic [NUM_REGS-1:0] r_sb_busy;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_div_busy;
  logic                w_raw;
  logic                w_waw;
  logic                w_strc;
  logic                w_hazard;
  logic [NUM_REGS-1:0] w_sb_set;
  logic [NUM_REGS-1:0] w_sb_clr;

  assign w_div_busy = (r_div_state == DIV_BUSY);

  // Hazards look only at registered state: a writeback this cycle releases the
  // consumer next cycle, keeping the wb path out of the issue timing path.
  assign w_raw  = (dec_rs1 && (dec_rs1_addr != '0) && r_sb_busy[dec_rs1_addr])
               || (dec_rs2 && (dec_rs2_addr != '0) && r_sb_busy[dec_rs2_addr]);
  assign w_waw  = dec_rd && (dec_rd_addr != '0) && r_sb_busy[dec_rd_addr];
  assign w_strc = dec_div && w_div_busy;
  assign w_hazard = dec_valid && (w_raw || w_waw || w_strc);

  assign pipe_flush = flush_req;
  assign pipe_stall = (w_hazard || ext_stall) && !flush_req;
  assign issue      = dec_valid && !w_hazard && !ext_stall && !flush_req;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (issue && dec_rd && dec_long && (dec_rd_addr != '0))
      w_sb_set[dec_rd_addr] = 1'b1;
    if (wb_valid && (wb_rd_addr != '0))
      w_sb_clr[wb_rd_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_busy <= '0;
    end else begin
      // Set is applied after clear so a forced same-index collision keeps the bit busy.
      r_sb_busy <= (r_sb_busy & ~w_sb_clr) | w_sb_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_state <= DIV_IDLE;
    end else begin
      case (r_div_state)
        DIV_IDLE: if (issue && dec_div) r_div_state <= DIV_BUSY;
        DIV_BUSY: if (div_done)         r_div_state <= DIV_IDLE;
        default:                        r_div_state <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !flush_req && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign sb_busy   = r_sb_busy;
  assign stall_cnt = r_stall_cnt;

  a_no_set_clr_collision: assert property (@(posedge clk) disable iff (!rst_n)
    ((w_sb_set & w_sb_clr) == '0))
    else $warning("scoreboard set and clear hit the same register in one cycle");

  a_wb_to_busy_reg: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_valid && (wb_rd_addr != '0) && !r_sb_busy[wb_rd_addr]))
    else $warning("writeback to a register that is not pending");

endmodule
